// File: rtl/axis_cabs_pkg.sv
// rtl/axis_cabs_pkg.sv - shared constants and width helpers for the complex-magnitude lanes.
// CABS_APPROX_EN selects alpha-max-beta-min magnitude instead of exact power.
package axis_cabs_pkg;

    localparam int CABS_DELAY = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int abs_width(input int word_width);
`ifdef CABS_APPROX_EN
        return word_width + 1;
`else
        return 2 * word_width + 1;
`endif
    endfunction

endpackage

// File: rtl/cabs_lane.sv
// rtl/cabs_lane.sv - one 3-stage magnitude engine with a tag travelling alongside the data.
// CABS_APPROX_EN selects abs/compare/shift-add; otherwise sign-extend/square/add.
module cabs_lane
    import axis_cabs_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_WIDTH-1:0]            i_word,
    input  logic [WORD_WIDTH-1:0]            q_word,
    input  logic [TAG_WIDTH-1:0]             tag_in,
    output logic [abs_width(WORD_WIDTH)-1:0] dout,
    output logic [TAG_WIDTH-1:0]             tag_out
);
    localparam int ABS_WIDTH = abs_width(WORD_WIDTH);

    logic [TAG_WIDTH-1:0] tag_pipe [CABS_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CABS_DELAY; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int k = 1; k < CABS_DELAY; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign tag_out = tag_pipe[CABS_DELAY-1];

`ifdef CABS_APPROX_EN
    // |-2^(W-1)| fits exactly in W unsigned bits, so no saturation is needed.
    logic [WORD_WIDTH-1:0] abs_i, abs_q, big, small;
    logic [ABS_WIDTH-1:0]  mag;

    always_ff @(posedge clk) begin
        abs_i <= i_word[WORD_WIDTH-1] ? (~i_word + WORD_WIDTH'(1)) : i_word;
        abs_q <= q_word[WORD_WIDTH-1] ? (~q_word + WORD_WIDTH'(1)) : q_word;
        if (abs_i >= abs_q) begin
            big   <= abs_i;
            small <= abs_q;
        end else begin
            big   <= abs_q;
            small <= abs_i;
        end
        mag <= {1'b0, big} + ABS_WIDTH'(small >> 1);
    end

    assign dout = mag;
`else
    logic signed [2*WORD_WIDTH-1:0] ext_i, ext_q;
    logic [2*WORD_WIDTH-1:0]        sq_i, sq_q;
    logic [ABS_WIDTH-1:0]           power;

    always_ff @(posedge clk) begin
        ext_i <= {{WORD_WIDTH{i_word[WORD_WIDTH-1]}}, i_word};
        ext_q <= {{WORD_WIDTH{q_word[WORD_WIDTH-1]}}, q_word};
        sq_i  <= ext_i * ext_i;
        sq_q  <= ext_q * ext_q;
        power <= {1'b0, sq_i} + {1'b0, sq_q};
    end

    assign dout = power;
`endif

endmodule

// File: rtl/axis_cabs_lanes.sv
// rtl/axis_cabs_lanes.sv - multi-lane complex-magnitude stage with credit-guarded output FIFO.
// CABS_APPROX_EN (see cabs_lane) switches the magnitude metric and ABS width.
module axis_cabs_lanes
    import axis_cabs_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int NUM_LANES     = 2,
    parameter int CHANNEL_WIDTH = 32,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                s_axis_tvalid,
    output logic                                                s_axis_tready,
    input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]               s_axis_tdata,
    input  logic                                                s_axis_tlast,
    output logic                                                m_axis_tvalid,
    input  logic                                                m_axis_tready,
    output logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]               m_axis_tdata,
    output logic [abs_width(CHANNEL_WIDTH/2)*NUM_CHANNELS-1:0]  m_axis_tdata_abs,
    output logic                                                m_axis_tlast
);
    localparam int WORD_WIDTH = CHANNEL_WIDTH / 2;
    localparam int PASSES     = NUM_CHANNELS / NUM_LANES;
    localparam int ABS_WIDTH  = abs_width(WORD_WIDTH);
    localparam int DW         = CHANNEL_WIDTH * NUM_CHANNELS;
    localparam int AW         = ABS_WIDTH * NUM_CHANNELS;
    localparam int PW         = (PASSES > 1) ? clog2(PASSES) : 1;
    localparam int TW         = PW + 2;
    localparam int AD         = clog2(FIFO_DEPTH);
    localparam int CRW        = AD + 1;

    logic                  hold_valid, hold_last, last_issue, accept, pop, credit_ok;
    logic [DW-1:0]         hold_data;
    logic [PW-1:0]         pass;
    logic [CRW-1:0]        credits;

    assign last_issue    = hold_valid && (pass == PW'(PASSES - 1));
    assign credit_ok     = credits < CRW'(FIFO_DEPTH);
    assign s_axis_tready = ~rst & credit_ok & (~hold_valid | last_issue);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            pass       <= '0;
        end else begin
            if (hold_valid) pass <= last_issue ? '0 : pass + PW'(1);
            if (accept) hold_valid <= 1'b1;
            else if (last_issue) hold_valid <= 1'b0;
        end
        if (accept) begin
            hold_data <= s_axis_tdata;
            hold_last <= s_axis_tlast;
        end
    end

    logic [WORD_WIDTH-1:0] lane_i   [NUM_LANES];
    logic [WORD_WIDTH-1:0] lane_q   [NUM_LANES];
    logic [ABS_WIDTH-1:0]  lane_abs [NUM_LANES];
    logic [TW-1:0]         lane_tag [NUM_LANES];
    logic [TW-1:0]         tag_in, ret_tag;

    assign tag_in = {hold_valid, last_issue, pass};

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_i[l] = hold_data[(int'(pass) * NUM_LANES + l) * CHANNEL_WIDTH +: WORD_WIDTH];
            lane_q[l] = hold_data[(int'(pass) * NUM_LANES + l) * CHANNEL_WIDTH + WORD_WIDTH +: WORD_WIDTH];
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        cabs_lane #(
            .WORD_WIDTH (WORD_WIDTH),
            .TAG_WIDTH  (TW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_word  (lane_i[l]),
            .q_word  (lane_q[l]),
            .tag_in  (tag_in),
            .dout    (lane_abs[l]),
            .tag_out (lane_tag[l])
        );
    end

    // Every lane carries an identical tag; OR-merging them keeps all copies live.
    always_comb begin
        ret_tag = '0;
        for (int l = 0; l < NUM_LANES; l++) ret_tag = ret_tag | lane_tag[l];
    end

    logic          ret_valid, ret_last;
    logic [PW-1:0] ret_pass;
    assign ret_valid = ret_tag[TW-1];
    assign ret_last  = ret_tag[TW-2];
    assign ret_pass  = ret_tag[PW-1:0];

    // Beat data follows the last pass through a delay line matched to the lanes.
    logic [DW-1:0] dly_data [CABS_DELAY];
    logic          dly_last [CABS_DELAY];
    logic [DW-1:0] asm_data;
    logic [AW-1:0] asm_abs;
    logic          asm_last, asm_push;

    always_ff @(posedge clk) begin
        dly_data[0] <= hold_data;
        dly_last[0] <= hold_last;
        for (int k = 1; k < CABS_DELAY; k++) begin
            dly_data[k] <= dly_data[k-1];
            dly_last[k] <= dly_last[k-1];
        end
        if (rst) asm_push <= 1'b0;
        else     asm_push <= ret_valid & ret_last;
        if (ret_valid) begin
            for (int l = 0; l < NUM_LANES; l++)
                asm_abs[(int'(ret_pass) * NUM_LANES + l) * ABS_WIDTH +: ABS_WIDTH] <= lane_abs[l];
        end
        if (ret_valid & ret_last) begin
            asm_data <= dly_data[CABS_DELAY-1];
            asm_last <= dly_last[CABS_DELAY-1];
        end
    end

    // Output register is the FIFO head; memory holds the entries queued behind it.
    logic [DW-1:0]  mem_data [FIFO_DEPTH];
    logic [AW-1:0]  mem_abs  [FIFO_DEPTH];
    logic           mem_last [FIFO_DEPTH];
    logic [AD-1:0]  wr_ptr, rd_ptr;
    logic [CRW-1:0] mem_count;
    logic           mem_empty, load_direct, mem_write, mem_read;

    assign mem_empty   = (mem_count == '0);
    assign load_direct = asm_push & (~m_axis_tvalid | (pop & mem_empty));
    assign mem_write   = asm_push & ~load_direct;
    assign mem_read    = pop & ~mem_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= '0;
            m_axis_tdata_abs <= '0;
            m_axis_tlast     <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            mem_count        <= '0;
            credits          <= '0;
        end else begin
            if (mem_write) begin
                mem_data[wr_ptr] <= asm_data;
                mem_abs[wr_ptr]  <= asm_abs;
                mem_last[wr_ptr] <= asm_last;
                wr_ptr           <= wr_ptr + AD'(1);
            end
            if (mem_read) begin
                m_axis_tdata     <= mem_data[rd_ptr];
                m_axis_tdata_abs <= mem_abs[rd_ptr];
                m_axis_tlast     <= mem_last[rd_ptr];
                rd_ptr           <= rd_ptr + AD'(1);
            end else if (load_direct) begin
                m_axis_tdata     <= asm_data;
                m_axis_tdata_abs <= asm_abs;
                m_axis_tlast     <= asm_last;
            end
            m_axis_tvalid <= mem_read | load_direct | (m_axis_tvalid & ~pop);
            mem_count     <= mem_count + CRW'(mem_write) - CRW'(mem_read);
            credits       <= credits + CRW'(accept) - CRW'(pop);
        end
    end

endmodule

// File: tb/tb_axis_cabs_lanes.sv
// tb/tb_axis_cabs_lanes.sv - directed and random checks of axis_cabs_lanes against a queue model.
// CABS_APPROX_EN selects the expected magnitude metric.
module tb_axis_cabs_lanes;
    localparam int NC  = 4;
    localparam int NL  = 2;
    localparam int CW  = 32;
    localparam int FD  = 8;
    localparam int DW  = NC * CW;
`ifdef CABS_APPROX_EN
    localparam int AW  = 17;
`else
    localparam int AW  = 33;
`endif
    localparam int AWB = AW * NC;

    logic            clk, rst;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0]   s_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [AWB-1:0]  m_axis_tdata_abs;

    axis_cabs_lanes #(
        .NUM_CHANNELS  (NC),
        .NUM_LANES     (NL),
        .CHANNEL_WIDTH (CW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tdata_abs (m_axis_tdata_abs),
        .m_axis_tlast     (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [AWB-1:0] abs_v;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    accepts = 0;
    int    pops = 0;

    function automatic logic [AWB-1:0] model_abs(input logic [DW-1:0] d);
        logic [AWB-1:0] r;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            logic signed [15:0] iv, qv;
            longint ai, aq, m;
            iv = d[ch*CW +: 16];
            qv = d[ch*CW+16 +: 16];
            ai = longint'(iv);
            aq = longint'(qv);
`ifdef CABS_APPROX_EN
            if (ai < 0) ai = -ai;
            if (aq < 0) aq = -aq;
            m = (ai > aq) ? ai + aq / 2 : aq + ai / 2;
`else
            m = ai * ai + aq * aq;
`endif
            r[ch*AW +: AW] = AW'(m);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: record handshakes seen before the edge, then advance to the next negedge.
    task automatic step();
        beat_t b;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (s_axis_tvalid && s_axis_tready) begin
                b.data  = s_axis_tdata;
                b.abs_v = model_abs(s_axis_tdata);
                b.last  = s_axis_tlast;
                exp_q.push_back(b);
                accepts++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 160'(exp_q.size()), 160'd1);
                end else begin
                    b = exp_q.pop_front();
                    check("out_tdata", m_axis_tdata, b.data);
                    check("out_abs", m_axis_tdata_abs, b.abs_v);
                    check("out_tlast", m_axis_tlast, b.last);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            n++;
        end
        check("drain_empty", 160'(exp_q.size()), 160'd0);
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0]  vec, ext;
        logic [AWB-1:0] vec_abs, ext_abs;
        int lat, cyc, n, acc0, pop0;

        vec = {32'h0000_0064, 32'h0001_FFFF, 32'h0000_0000, 32'hFFFC_0003};
        ext = {4{32'h8000_8000}};
`ifdef CABS_APPROX_EN
        vec_abs = {17'd100, 17'd1, 17'd0, 17'd5};
        ext_abs = {4{17'd49152}};
`else
        vec_abs = {33'd10000, 33'd2, 33'd0, 33'd25};
        ext_abs = {4{33'd2147483648}};
`endif

        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = vec;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_s_tready", s_axis_tready, 1'b0);
            check("rst_m_tvalid", m_axis_tvalid, 1'b0);
            check("rst_m_tdata", m_axis_tdata, '0);
            check("rst_m_abs", m_axis_tdata_abs, '0);
            check("rst_m_tlast", m_axis_tlast, 1'b0);
        end

        rst = 1'b0;
        #1;
        check("release_s_tready", s_axis_tready, 1'b1);
        step();
        check("first_accept", 160'(accepts), 160'd1);
        s_axis_tvalid = 1'b0;
        lat = 0;
        while (!m_axis_tvalid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 160'(lat), 160'd6);
        check("vec_abs", m_axis_tdata_abs, vec_abs);
        check("vec_tdata", m_axis_tdata, vec);
        drain(20);

        s_axis_tdata  = ext;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        lat = 0;
        while (!m_axis_tvalid && lat < 20) begin
            step();
            lat++;
        end
        check("ext_latency", 160'(lat), 160'd6);
        check("ext_abs", m_axis_tdata_abs, ext_abs);
        drain(20);

        // Back-to-back random beats with a free-running sink.
        acc0 = accepts;
        cyc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_data();
        s_axis_tlast  = 1'($urandom_range(0, 1));
        while (accepts - acc0 < 20 && cyc < 200) begin
            n = accepts;
            step();
            cyc++;
            if (accepts != n) begin
                s_axis_tdata = rand_data();
                s_axis_tlast = 1'($urandom_range(0, 1));
            end
        end
        s_axis_tvalid = 1'b0;
        check("b2b_count", 160'(accepts - acc0), 160'd20);
        check("b2b_cycles", 160'(cyc), 160'd39);
        drain(40);

        // Stalled sink: credits must cap acceptance at the FIFO depth.
        m_axis_tready = 1'b0;
        acc0 = accepts;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = accepts;
            step();
            if (accepts != n) begin
                s_axis_tdata = rand_data();
                s_axis_tlast = 1'($urandom_range(0, 1));
            end
        end
        s_axis_tvalid = 1'b0;
        #1;
        check("stall_accepts", 160'(accepts - acc0), 160'(FD));
        check("stall_s_tready", s_axis_tready, 1'b0);
        m_axis_tready = 1'b1;
        pop0 = pops;
        drain(100);
        check("stall_pops", 160'(pops - pop0), 160'(FD));
        step();
        check("stall_idle", m_axis_tvalid, 1'b0);

        // Reset with three beats in flight.
        acc0 = accepts;
        cyc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rand_data();
        while (accepts - acc0 < 3 && cyc < 50) begin
            n = accepts;
            step();
            cyc++;
            if (accepts != n) s_axis_tdata = rand_data();
        end
        s_axis_tvalid = 1'b0;
        check("pre_rst_accepts", 160'(accepts - acc0), 160'd3);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        pop0 = pops;
        for (int i = 0; i < 15; i++) step();
        check("post_rst_pops", 160'(pops - pop0), 160'd0);
        check("post_rst_m_tvalid", m_axis_tvalid, 1'b0);

        s_axis_tdata  = rand_data();
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        drain(30);
        check("post_rst_beat", 160'(pops - pop0), 160'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_cabs_lanes.md
# axis_cabs_lanes

Parametrised multi-channel complex-magnitude stage for the peak path: accepts one AXI-Stream beat of NUM_CHANNELS packed I/Q words, computes a per-channel magnitude metric on NUM_LANES parallel engines time-multiplexed over the channels, and emits the original data alongside a packed magnitude bus. It generalises the single-engine serial stage with a configurable lane count, synchronous reset, a built-in output FIFO with credit flow control (the engine pipeline never stalls), and tlast pass-through.

## Interface
- NUM_CHANNELS, 4, channels per beat; must be a multiple of NUM_LANES
- NUM_LANES, 2, parallel magnitude engines (1..NUM_CHANNELS)
- CHANNEL_WIDTH, 32, bits per channel; I = [W/2-1:0], Q = [W-1:W/2], both signed two's complement
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2)
- derived: WORD_WIDTH = CHANNEL_WIDTH/2; PASSES = NUM_CHANNELS/NUM_LANES; ABS_WIDTH per channel (see Configuration)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  CHANNEL_WIDTH*NUM_CHANNELS  packed channels, channel n at [n*W +: W]
- s_axis_tlast  in  1  frame marker, carried with beat
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  CHANNEL_WIDTH*NUM_CHANNELS  input data, unchanged
- m_axis_tdata_abs  out  ABS_WIDTH*NUM_CHANNELS  magnitude of channel n at [n*ABS_WIDTH +: ABS_WIDTH]
- m_axis_tlast  out  1  tlast of the same beat

## Operation
- Accepted beat (tvalid & tready) latched into holding register with tlast.
- Sequencer: pass counter p = 0..PASSES-1; pass p feeds channels p*NUM_LANES .. p*NUM_LANES+NUM_LANES-1 to lanes 0..NUM_LANES-1. Counter wraps to 0 after last pass; idle when holding register empty.
- Each lane has fixed latency CABS_DELAY = 3, no enable; results written into assembly register at slot of their channel index (tagged through the pipe with p and a last-pass flag).
- When last-pass results retire, {data, abs, tlast} pushed into FIFO the next cycle.
- Credits: beats in flight (holding + pipeline + assembly) + FIFO occupancy < FIFO_DEPTH required for acceptance; so a push never finds the FIFO full.
- s_axis_tready = ~rst_state & credit_ok & (holding empty | last pass issuing this cycle).
- FIFO simultaneous push and pop allowed at any occupancy; pop on m_axis_tvalid & m_axis_tready. m_axis_* driven from FIFO head, registered.
- Reset: FIFO empty, holding/pipeline valid flags cleared, pass counter 0; in-flight beats discarded, no partial output ever emitted. Output resets: s_axis_tready 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tdata_abs 0, m_axis_tlast 0. s_axis_tready may rise the first cycle after rst deasserts.

## Timing
- Latency: beat accepted at edge t -> m_axis_tvalid high after edge t + PASSES + CABS_DELAY + 1 (FIFO empty, m_tready irrelevant). PASSES=2 -> 6 cycles.
- Throughput: one beat per PASSES cycles sustained while credits exist; PASSES=1 -> one beat per cycle.
- m_axis_tdata/abs/tlast stable while m_axis_tvalid & ~m_axis_tready.
- No combinational path from m_axis_tready to s_axis_tready.

## Configuration
- CABS_APPROX_EN undefined: exact power, |I|^2+|Q|^2, unsigned, ABS_WIDTH = 2*WORD_WIDTH+1; lane stages: sign-extend/register, square, add.
- CABS_APPROX_EN defined: alpha-max-beta-min magnitude, max(|I|,|Q|) + (min(|I|,|Q|) >> 1), unsigned, ABS_WIDTH = WORD_WIDTH+1; lane stages: abs, compare/swap, shift-add. Latency identical (3) in both modes.
- |-2^(W-1)| = 2^(W-1) represented exactly in both modes (no saturation).

## Structure
- Package axis_cabs_pkg: clog2 function, CABS_DELAY constant, ABS_WIDTH derivation function keyed on the macro.
- Sub-module cabs_lane: one pipelined magnitude engine (din I/Q, tag in, dout, tag out); instantiated NUM_LANES times. FIFO and sequencer stay in the top.

## Test plan
- Reset values: hold rst 3 cycles with s_tvalid=1 -> all outputs 0, no acceptance; first beat accepted cycle after release.
- NUM_CHANNELS=4, NUM_LANES=2, W=32; ch0 I=3,Q=-4, ch1 I=0,Q=0, ch2 I=-1,Q=1, ch3 I=100,Q=0 -> abs {25,0,2,10000} exact; {5,0,1,100} approx; m_tvalid 6 cycles after accept; tdata echoed.
- Extremes: I=Q=-32768 -> exact 2147483648 (33 bits), approx 49152 (17 bits).
- Back-to-back 20 beats, m_tready=1 -> s_tready duty 1/2 (PASSES=2), outputs in order, tlast preserved.
- m_tready=0 -> exactly FIFO_DEPTH beats accepted then s_tready=0; release -> all 8 drained in order, none lost or duplicated.
- rst asserted mid-stream with 3 beats in flight -> no output beat after reset, FIFO empty, next beat processed correctly.
